// File: rtl/alu_muldiv_seq_if.sv
// ---------------------------------------------------------------------------
// alu_muldiv_seq_if
// Bundle between the EX stage and the RV32M multiply/divide sequencer.
//   start   : EX holds a valid M-extension op (request)
//   funct3  : operation select (MUL..REMU)
//   op_a    : rs1 value
//   op_b    : rs2 value
//   stall   : freeze IF/ID/EX pipeline registers
//   busy    : sequencer is not idle
//   done    : one-cycle pulse, result valid
//   result  : final value, held until the next done
// Modports: master = EX stage side, slave = sequencer side.
// ---------------------------------------------------------------------------
interface alu_muldiv_seq_if #(
  parameter int WIDTH = 32
) ();
  logic             start;
  logic [2:0]       funct3;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             stall;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output start, funct3, op_a, op_b,
    input  stall, busy, done, result
  );

  modport slave (
    input  start, funct3, op_a, op_b,
    output stall, busy, done, result
  );
endinterface

// File: rtl/alu_muldiv_seq.sv
// ---------------------------------------------------------------------------
// alu_muldiv_seq
// Multi-cycle RV32M multiply/divide sequencer sitting beside the EX-stage ALU.
// Multiply is a radix-2 shift-add over operand magnitudes, divide is a
// restoring shift-subtract; signs are re-applied in a single FIX cycle.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous, active-high reset (aborts any op, no done pulse)
//   bus  : alu_muldiv_seq_if.slave (start/funct3/op_a/op_b in,
//          stall/busy/done/result out)
// Latency: start sampled at edge N -> done in cycle N+WIDTH+2, or N+1 for a
// divide/remainder by zero.
// ---------------------------------------------------------------------------
module alu_muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic            clk,
  input  logic            rst,
  alu_muldiv_seq_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_nx;

  logic [2:0]       f3;
  logic             sa, sb;       // effective operand signs (0 for unsigned use)
  logic [WIDTH-1:0] acc;          // product high half / partial remainder
  logic [WIDTH-1:0] lo;           // multiplier -> product low half / dividend -> quotient
  logic [WIDTH-1:0] opnd;         // multiplicand or divisor magnitude
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] result_r;

  logic             stall_c, busy_c, done_c;
  logic             sa_in, sb_in, div_zero;
  logic [WIDTH-1:0] mag_a, mag_b, dz_val;
  logic [WIDTH:0]   sum, rem_sh, rem_sub;
  logic             rem_ge;
  logic [WIDTH-1:0] acc_nx, lo_nx, fix_val;
  logic [2*WIDTH-1:0] prod_fix;

  function automatic logic [WIDTH-1:0] cneg(input logic [WIDTH-1:0] v, input logic n);
    return n ? ('0 - v) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cneg2(input logic [2*WIDTH-1:0] v, input logic n);
    return n ? ('0 - v) : v;
  endfunction

  assign div_zero = bus.funct3[2] && (bus.op_b == '0);

  // ---- FSM: state register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // ---- FSM: next state and control outputs ----
  always_comb begin
    state_nx = state;
    stall_c  = 1'b0;
    busy_c   = (state != IDLE);
    done_c   = 1'b0;
    case (state)
      IDLE: begin
        stall_c = bus.start;
        if (bus.start) state_nx = div_zero ? DONE : CALC;
      end
      CALC: begin
        stall_c = 1'b1;
        if (count == CNT_W'(WIDTH - 1)) state_nx = FIX;
      end
      FIX: begin
        stall_c  = 1'b1;
        state_nx = DONE;
      end
      DONE: begin
        // stall drops here so the pipeline captures result this cycle
        done_c   = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // ---- accept stage: sign flags and magnitudes of the incoming operands ----
  always_comb begin
    // op_a signed for MUL/MULH/MULHSU/DIV/REM, op_b signed for MULH/DIV/REM
    sa_in  = bus.op_a[WIDTH-1] & (bus.funct3[2] ? ~bus.funct3[0] : (bus.funct3[1:0] != 2'b11));
    sb_in  = bus.op_b[WIDTH-1] & (bus.funct3[2] ? ~bus.funct3[0] : (bus.funct3[1:0] == 2'b01));
    mag_a  = cneg(bus.op_a, sa_in);
    mag_b  = cneg(bus.op_b, sb_in);
    // divide by zero: quotient all ones, remainder is raw op_a
    dz_val = bus.funct3[1] ? bus.op_a : '1;
  end

  // ---- iteration stage: one shift-add or shift-subtract step ----
  always_comb begin
    sum     = {1'b0, acc} + (lo[0] ? {1'b0, opnd} : '0);
    rem_sh  = {acc, lo[WIDTH-1]};
    rem_ge  = (rem_sh >= {1'b0, opnd});
    rem_sub = rem_sh - {1'b0, opnd};
    if (f3[2]) begin
      acc_nx = rem_ge ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
      lo_nx  = {lo[WIDTH-2:0], rem_ge};
    end else begin
      // carry out of the add becomes the new MSB after the right shift
      acc_nx = sum[WIDTH:1];
      lo_nx  = {sum[0], lo[WIDTH-1:1]};
    end
  end

  // ---- fix stage: sign correction and output select ----
  always_comb begin
    prod_fix = cneg2({acc, lo}, sa ^ sb);
    case (f3)
      3'b000:                fix_val = prod_fix[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: fix_val = prod_fix[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:        fix_val = cneg(lo, sa ^ sb);
      default:               fix_val = cneg(acc, sa);  // remainder follows dividend sign
    endcase
  end

  // ---- datapath registers ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f3       <= '0;
      sa       <= 1'b0;
      sb       <= 1'b0;
      acc      <= '0;
      lo       <= '0;
      opnd     <= '0;
      count    <= '0;
      result_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            f3    <= bus.funct3;
            sa    <= sa_in;
            sb    <= sb_in;
            acc   <= '0;
            count <= '0;
            if (bus.funct3[2]) begin
              lo   <= mag_a;
              opnd <= mag_b;
            end else begin
              lo   <= mag_b;
              opnd <= mag_a;
            end
            if (div_zero) result_r <= dz_val;
          end
        end
        CALC: begin
          acc   <= acc_nx;
          lo    <= lo_nx;
          count <= count + CNT_W'(1);
        end
        FIX:     result_r <= fix_val;
        default: ;
      endcase
    end
  end

  assign bus.stall  = stall_c;
  assign bus.busy   = busy_c;
  assign bus.done   = done_c;
  assign bus.result = result_r;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_muldiv_seq
// Scoreboard bench for alu_muldiv_seq: stimulus pushes the expected result
// and done cycle, a negedge monitor pops and compares on every done pulse.
// ---------------------------------------------------------------------------
module tb_alu_muldiv_seq;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  typedef struct {
    logic [W-1:0] res;
    int           at;
  } exp_t;

  exp_t exp_q[$];

  alu_muldiv_seq_if #(.WIDTH(W)) bus ();

  alu_muldiv_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: plain 64-bit arithmetic following the RV32M rules.
  function automatic logic [W-1:0] ref_model(input logic [2:0] f, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    longint       sa_l, sb_l, ua_l, ub_l;
    logic [63:0]  p;
    sa_l = $signed(a);
    sb_l = $signed(b);
    ua_l = {32'h0, a};
    ub_l = {32'h0, b};
    case (f)
      3'd0: begin p = sa_l * sb_l; return p[31:0]; end
      3'd1: begin p = sa_l * sb_l; return p[63:32]; end
      3'd2: begin p = sa_l * ub_l; return p[63:32]; end
      3'd3: begin p = ua_l * ub_l; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(sa_l / sb_l);
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return 32'(ua_l / ub_l);
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(sa_l % sb_l);
      end
      default: begin
        if (b == 0) return a;
        return 32'(ua_l % ub_l);
      end
    endcase
  endfunction

  function automatic int latency(input logic [2:0] f, input logic [W-1:0] b);
    return (f[2] && b == 0) ? 1 : W + 2;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int c);
    exp_t e;
    e.res = ref_model(f, a, b);
    e.at  = c + latency(f, b);
    exp_q.push_back(e);
  endtask

  // Waits for IDLE, presents one op for a single cycle; returns its accept cycle.
  task automatic issue(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                       output int c);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy) begin
      tests++;
      fails++;
      $display("FAIL issue_wait: busy=%b after %0d cycles, expected 0", bus.busy, n);
    end
    bus.start  = 1'b1;
    bus.funct3 = f;
    bus.op_a   = a;
    bus.op_b   = b;
    c = cyc;
    push_exp(f, a, b, c);
    #1;
    check("stall_on_accept", {31'h0, bus.stall}, 32'h1);
    @(negedge clk);
    bus.start = 1'b0;
    bus.op_a  = $urandom;
    bus.op_b  = $urandom;
  endtask

  // ---- monitor ----
  always @(negedge clk) begin
    if (!rst && bus.done) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_done: result=%h at cycle %0d, expected no done", bus.result, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (bus.result !== e.res || cyc != e.at) begin
          fails++;
          $display("FAIL result: got %h at cycle %0d, expected %h at cycle %0d",
                   bus.result, cyc, e.res, e.at);
        end
      end
    end
  end

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 6))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h1;
      4:       return 32'($urandom_range(1, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int c;
    int n;
    logic [2:0] f;
    logic [W-1:0] a, b;

    bus.start  = 1'b0;
    bus.funct3 = 3'b000;
    bus.op_a   = '0;
    bus.op_b   = '0;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_stall",  {31'h0, bus.stall}, 32'h0);
    check("rst_busy",   {31'h0, bus.busy},  32'h0);
    check("rst_done",   {31'h0, bus.done},  32'h0);
    check("rst_result", bus.result, 32'h0);
    rst = 1'b0;

    // MUL 7x6 with cycle-by-cycle stall profile
    issue(3'b000, 32'd7, 32'd6, c);
    for (int k = 1; k <= 34; k++) begin
      check($sformatf("stall_k%0d", k), {31'h0, bus.stall}, (k < 34) ? 32'h1 : 32'h0);
      if (k < 34) @(negedge clk);
    end

    // directed cases from the RV32M rules
    issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, c);
    issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, c);
    issue(3'b010, 32'hFFFF_FFFF, 32'd2, c);
    issue(3'b100, 32'hFFFF_FFF9, 32'd2, c);
    issue(3'b110, 32'hFFFF_FFF9, 32'd2, c);
    issue(3'b101, 32'd100, 32'd7, c);
    issue(3'b111, 32'd100, 32'd7, c);
    issue(3'b101, 32'd5, 32'd0, c);
    issue(3'b110, 32'd5, 32'd0, c);
    issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, c);
    issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, c);
    issue(3'b000, 32'h8000_0000, 32'hFFFF_FFFF, c);

    // start pulsed mid-op with different operands is ignored
    issue(3'b000, 32'd1234, 32'd5678, c);
    repeat (4) @(negedge clk);
    bus.start  = 1'b1;
    bus.funct3 = 3'b100;
    bus.op_a   = 32'd999;
    bus.op_b   = 32'd0;
    @(negedge clk);
    bus.start  = 1'b0;

    // start held through DONE: second op is taken in the following IDLE cycle
    n = 0;
    while ((bus.busy || exp_q.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    bus.start  = 1'b1;
    bus.funct3 = 3'b011;
    bus.op_a   = 32'hDEAD_BEEF;
    bus.op_b   = 32'h1234_5678;
    c = cyc;
    push_exp(3'b011, 32'hDEAD_BEEF, 32'h1234_5678, c);
    @(negedge clk);
    bus.funct3 = 3'b101;
    bus.op_a   = 32'd100;
    bus.op_b   = 32'd7;
    push_exp(3'b101, 32'd100, 32'd7, c + W + 3);
    repeat (35) @(negedge clk);
    bus.start  = 1'b0;

    // reset at CALC count=10 aborts the op
    issue(3'b000, 32'd123, 32'd456, c);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("abort_stall",  {31'h0, bus.stall}, 32'h0);
    check("abort_busy",   {31'h0, bus.busy},  32'h0);
    check("abort_done",   {31'h0, bus.done},  32'h0);
    check("abort_result", bus.result, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    issue(3'b000, 32'd3, 32'd3, c);

    // randomized ops with corner-weighted operands and random idle gaps
    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom_range(0, 7));
      a = pick_operand();
      b = pick_operand();
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(f, a, b, c);
    end

    // drain
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
    end
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
